// File: rtl/fpdiv_req_queue.sv
// Request FIFO and single-tag tracker in front of the scalar radix-64 FP divider.
// Issues one divide at a time, tags the returning result, and forwards flush.
module fpdiv_req_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [1:0]                 req_fp_format_i,
   input  logic [63:0]                req_opa_i,
   input  logic [63:0]                req_opb_i,
   input  logic [2:0]                 req_rm_i,
   input  logic [TAG_W-1:0]           req_tag_i,
   output logic                       div_start_valid_o,
   input  logic                       div_start_ready_i,
   output logic [1:0]                 div_fp_format_o,
   output logic [63:0]                div_opa_o,
   output logic [63:0]                div_opb_o,
   output logic [2:0]                 div_rm_o,
   output logic                       div_flush_o,
   input  logic                       div_finish_valid_i,
   output logic                       div_finish_ready_o,
   input  logic [63:0]                div_res_i,
   input  logic [4:0]                 div_fflags_i,
   output logic                       resp_valid_o,
   input  logic                       resp_ready_i,
   output logic [63:0]                resp_res_o,
   output logic [4:0]                 resp_fflags_o,
   output logic [TAG_W-1:0]           resp_tag_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int PL_W  = 2 + 64 + 64 + 3 + TAG_W;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state;
   logic [PL_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [TAG_W-1:0]   inflight_tag;
   logic [TAG_W-1:0]   head_tag;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic               busy;
   logic               full;
   logic               empty;
   logic               push;
   logic               start;
   logic               finish;

   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign rd_idx = rd_ptr[IDX_W-1:0];
   assign busy   = (state == BUSY);

   // Wrap bit distinguishes full from empty when the index bits match.
   assign full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign empty = (wr_ptr == rd_ptr);

   assign req_ready_o       = !full && !flush_i;
   assign div_start_valid_o = !busy && !empty && !flush_i;
   assign div_flush_o       = flush_i;

   assign push   = req_valid_i && req_ready_o;
   assign start  = div_start_valid_o && div_start_ready_i;
   assign finish = resp_valid_o && resp_ready_i;

   assign {div_fp_format_o, div_opa_o, div_opb_o, div_rm_o, head_tag} = mem[rd_idx];

   // Results arriving while idle (stale after a flush) are drained and dropped.
   assign resp_valid_o       = div_finish_valid_i && busy && !flush_i;
   assign div_finish_ready_o = resp_ready_i || !busy || flush_i;
   assign resp_res_o         = div_res_i;
   assign resp_fflags_o      = div_fflags_i;
   assign resp_tag_o         = inflight_tag;

   assign occupancy_o = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= {req_fp_format_i, req_opa_i, req_opb_i, req_rm_i, req_tag_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (start) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         inflight_tag <= '0;
      end else if (flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= BUSY;
                  inflight_tag <= head_tag;
               end
            end
            BUSY: begin
               if (finish) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
